fixed_dot_accumulator: RTL
==========================

FIXED_DOT_ACCUMULATOR -- requirements
Module: fixed_dot_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of each signed product lane.
REQ-002 SHALL have parameter IN_SIZE, default 4: lanes per input beat.
REQ-003 SHALL have parameter ACC_DEPTH, default 4: beats summed per output result.
REQ-004 SHALL have parameter OUT_WIDTH, default IN_WIDTH + $clog2(IN_SIZE) + $clog2(ACC_DEPTH): result width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, IN_WIDTH x [IN_SIZE-1:0] unpacked: signed product vector.
REQ-008 SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1): input handshake.
REQ-009 SHALL have port data_out, output, OUT_WIDTH: signed accumulated dot-product result.
REQ-010 SHALL have ports data_out_valid (output, 1) and data_out_ready (input, 1): output handshake.

Function
REQ-011 SHALL treat a transfer as occurring on a rising edge where valid and ready are both high, on either port.
REQ-012 SHALL sign-extend every lane to OUT_WIDTH and sum all IN_SIZE lanes combinationally into beat_sum.
REQ-013 SHALL register beat_sum into stage-1 register S1, with flag s1_valid, on each input transfer.
REQ-014 SHALL drive data_in_ready = !s1_valid || s1_advance, where s1_advance means S1 is consumed this cycle; no combinational path from data_in_valid to data_in_ready.
REQ-015 SHALL keep beat counter cnt (0..ACC_DEPTH-1) and accumulator acc (OUT_WIDTH, signed).
REQ-016 SHALL assert s1_advance when s1_valid && !(cnt == ACC_DEPTH-1 && data_out_valid && !data_out_ready).
REQ-017 SHALL, on s1_advance with cnt < ACC_DEPTH-1: acc <= acc + S1 (acc taken as 0 when cnt == 0); cnt <= cnt + 1.
REQ-018 SHALL, on s1_advance with cnt == ACC_DEPTH-1: data_out <= acc + S1; data_out_valid <= 1; acc <= 0; cnt <= 0.
REQ-019 SHALL clear data_out_valid on an output transfer unless REQ-018 loads a new result in the same cycle; if it does, the new result replaces the old and data_out_valid stays high.
REQ-020 SHALL hold data_out stable while data_out_valid is high and data_out_ready is low.
REQ-021 SHALL stall only on the final beat of a group; non-final beats keep accumulating while a result waits unaccepted.
REQ-022 SHALL have latency 2 cycles from the final input transfer to data_out_valid when unstalled, with sustained throughput of one beat per cycle.
REQ-023 SHALL, for ACC_DEPTH == 1, emit one result per beat; cnt stays 0.
REQ-024 SHALL use two's-complement wrap on overflow; no saturation (default OUT_WIDTH cannot overflow).
REQ-025 SHALL keep input-order grouping: results correspond to consecutive ACC_DEPTH-beat groups, with no beat dropped or duplicated under any valid/ready pattern.

Reset
REQ-026 SHALL, while rst is low, asynchronously clear s1_valid, S1, cnt, acc, data_out (0) and data_out_valid (0).
REQ-027 SHALL drive data_in_ready high from the first cycle after rst deasserts.
REQ-028 SHALL discard a partial group in progress when reset is asserted; the next group starts at cnt == 0.

Verification (IN_WIDTH=8, IN_SIZE=4, ACC_DEPTH=3, OUT_WIDTH=12)
REQ-029 SHALL cover: beats {1,2,3,4},{5,6,7,8},{-1,-1,-1,-1} on consecutive cycles with data_out_ready=1 -> data_out=32, valid 2 cycles after third transfer, high for one cycle.
REQ-030 SHALL cover: three beats of all -128 -> data_out=-1536 (12'hA00); all 127 -> 1524.
REQ-031 SHALL cover: data_out_ready=0 with a result pending, then 3 more beats offered -> 2 beats accepted, third held in S1, data_in_ready=0; after ready rises, second result appears next cycle.
REQ-032 SHALL cover: continuous input with data_out_ready=1 -> one result every 3 cycles, data_in_ready never low.
REQ-033 SHALL cover: rst pulsed low after 2 beats of a group -> outputs 0, then 3 fresh beats of {1,1,1,1} -> data_out=12.
REQ-034 SHALL cover: random valid/ready toggling over 1000 beats against a reference model -> all results match, in order.

Source files
------------

// File: rtl/fixed_dot_accumulator.sv
// Streaming dot-product accumulator: sums the lanes of each signed input beat,
// then sums ACC_DEPTH consecutive beats into one result behind a valid/ready handshake.
module fixed_dot_accumulator #(
  parameter int IN_WIDTH  = 32,
  parameter int IN_SIZE   = 4,
  parameter int ACC_DEPTH = 4,
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_SIZE) + $clog2(ACC_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
);

  localparam int CNT_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_DEPTH - 1);

  function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
    return OUT_WIDTH'(x);
  endfunction

  // Two's-complement wrap: the result is simply truncated to OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] wrap_add(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] b
  );
    return OUT_WIDTH'(a + b);
  endfunction

  logic signed [OUT_WIDTH-1:0] beat_sum;
  logic signed [OUT_WIDTH-1:0] s1_data;
  logic                        s1_valid;
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [OUT_WIDTH-1:0] acc_base;
  logic signed [OUT_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]            cnt;
  logic                        last_beat;
  logic                        out_stall;
  logic                        out_fire;
  logic                        in_fire;
  logic                        s1_advance;

  // Stage 0: combinational lane reduction of the incoming beat
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      beat_sum = wrap_add(beat_sum, sext(data_in[i]));
    end
  end

  // Only the final beat of a group waits on the output register.
  assign last_beat     = (cnt == LAST_CNT);
  assign out_stall     = data_out_valid && !data_out_ready;
  assign out_fire      = data_out_valid && data_out_ready;
  assign s1_advance    = s1_valid && !(last_beat && out_stall);
  assign data_in_ready = !s1_valid || s1_advance;
  assign in_fire       = data_in_valid && data_in_ready;
  assign acc_base      = (cnt == '0) ? '0 : acc;
  assign acc_next      = wrap_add(acc_base, s1_data);

  // Stage 1: beat sum register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_data  <= beat_sum;
        s1_valid <= 1'b1;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: group accumulator and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc            <= '0;
      cnt            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (out_fire) begin
        data_out_valid <= 1'b0;
      end
      if (s1_advance) begin
        if (last_beat) begin
          data_out       <= acc_next;
          data_out_valid <= 1'b1;
          acc            <= '0;
          cnt            <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
